// File: rtl/drc_pkg.sv
// drc_pkg: shared types and constants for the DMA read-path write scheduler and pusher
// Contents: scheduler state encoding, AXI write-response codes,
//           burst-descriptor field offsets, response classification helper.
package drc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_OFFER     = 2'b01,
        ST_WAIT_DONE = 2'b10
    } sched_state_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam int BD_LEN_LSB  = 0;
    localparam int BD_LEN_MSB  = 7;
    localparam int BD_ADDR_LSB = 8;
    localparam int BD_ADDR_MSB = 39;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/drc_rr_pick.sv
// drc_rr_pick: combinational rotating-priority picker
// Ports:
//   eligible_i  per-requester eligibility vector
//   ptr_i       rotating priority pointer; search starts at this index
//   grant_o     one-hot pick (zero when nothing eligible)
//   idx_o       binary index of the pick
//   any_o       at least one requester eligible
module drc_rr_pick #(
    parameter int p_paths    = 2,
    parameter int p_ptr_bits = $clog2(p_paths)
) (
    input  logic [p_paths-1:0]    eligible_i,
    input  logic [p_ptr_bits-1:0] ptr_i,
    output logic [p_paths-1:0]    grant_o,
    output logic [p_ptr_bits-1:0] idx_o,
    output logic                  any_o
);

    int j;

    // Walk offsets from farthest to nearest so the last hit is the first
    // eligible index at or after the pointer.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        j       = 0;
        for (int k = p_paths - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % p_paths;
            if (eligible_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
                idx_o      = p_ptr_bits'(j);
            end
        end
    end

    assign any_o = |eligible_i;

endmodule

// File: rtl/drc_write_scheduler.sv
// drc_write_scheduler: round-robin grant of the shared AXI write pusher to DMA read paths
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_enable                allow new grants (in-flight burst always completes)
//   paths_burst_empty       per-path burst-descriptor FIFO empty flags
//   sched_grant/_valid      registered one-hot grant and offer strobe to pusher
//   sched_grant_ready       pusher accepts the offered grant
//   done_valid/done_resp    write-response handshake pulse and its bresp
//   busy                    scheduler not idle
//   path_burst_cnt          per-path completed-burst counters, path i at [i*p_cnt_bits +: p_cnt_bits]
//   path_err/err_clr        sticky per-path error flags and clear pulses
// Build option: DRC_SCHED_ERR_EN enables error tracking and exclusion of errored paths.
module drc_write_scheduler
    import drc_pkg::*;
#(
    parameter int p_paths    = 2,
    parameter int p_cnt_bits = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic [p_paths-1:0]            paths_burst_empty,
    output logic [p_paths-1:0]            sched_grant,
    output logic                          sched_grant_valid,
    input  logic                          sched_grant_ready,
    input  logic                          done_valid,
    input  logic [1:0]                    done_resp,
    output logic                          busy,
    output logic [p_paths*p_cnt_bits-1:0] path_burst_cnt,
    output logic [p_paths-1:0]            path_err,
    input  logic [p_paths-1:0]            err_clr
);

    localparam int p_ptr_bits = $clog2(p_paths);

    sched_state_e              state_q, state_d;
    logic [p_paths-1:0]        grant_q, grant_d;
    logic                      valid_q, valid_d;
    logic [p_ptr_bits-1:0]     idx_q, idx_d;
    logic [p_ptr_bits-1:0]     rr_ptr_q, rr_ptr_d;
    logic                      busy_q;
    logic [p_cnt_bits-1:0]     cnt_q [p_paths];
    logic [p_paths-1:0]        eligible;
    logic [p_paths-1:0]        pick_grant;
    logic [p_ptr_bits-1:0]     pick_idx;
    logic                      pick_any;
    logic                      done_fire;

    drc_rr_pick #(
        .p_paths   (p_paths),
        .p_ptr_bits(p_ptr_bits)
    ) u_pick (
        .eligible_i(eligible),
        .ptr_i     (rr_ptr_q),
        .grant_o   (pick_grant),
        .idx_o     (pick_idx),
        .any_o     (pick_any)
    );

    assign done_fire = (state_q == ST_WAIT_DONE) && done_valid;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: if (i_enable && pick_any) begin
                grant_d = pick_grant;
                idx_d   = pick_idx;
                valid_d = 1'b1;
                state_d = ST_OFFER;
            end
            ST_OFFER: if (sched_grant_ready) begin
                valid_d = 1'b0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (done_valid) begin
                grant_d  = '0;
                rr_ptr_d = (idx_q == p_ptr_bits'(p_paths - 1)) ? '0 : idx_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= state_d != ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < p_paths; i++) begin
            if (i_rst)
                cnt_q[i] <= '0;
            else if (done_fire && grant_q[i])
                cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end

    for (genvar g = 0; g < p_paths; g++) begin : g_cnt
        assign path_burst_cnt[g*p_cnt_bits +: p_cnt_bits] = cnt_q[g];
    end

`ifdef DRC_SCHED_ERR_EN
    logic [p_paths-1:0] err_q;
    logic [p_paths-1:0] err_set;

    assign err_set = (done_fire && resp_is_err(done_resp)) ? grant_q : '0;

    // Set is applied after clear so a coincident set wins.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            err_q <= '0;
        else
            err_q <= (err_q & ~err_clr) | err_set;
    end

    assign eligible = ~paths_burst_empty & ~err_q;
    assign path_err = err_q;
`else
    logic unused_err;

    assign unused_err = ^{err_clr, done_resp};
    assign eligible   = ~paths_burst_empty;
    assign path_err   = '0;
`endif

    assign sched_grant       = grant_q;
    assign sched_grant_valid = valid_q;
    assign busy              = busy_q;

endmodule
